// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch: program counter register with a RUN/HALT fetch-control FSM and
// optional execution statistics counters.
//
// The PC never computes its own successor. The upstream next-PC calculator
// supplies in_pcin, and the value is latched verbatim whenever out_pc_en is
// high. A level-sensitive in_halt (decoded syscall) parks the machine in
// HALT. A single-cycle in_go pulse from the operator panel resumes it and
// loads in_pcin, which advances past the halting instruction.
//
// Optional feature macro: PC_FETCH_STATS_EN
//   defined   -> out_cycles / out_jumps / out_branches are saturating counters
//   undefined -> counter registers are absent and those outputs are tied to 0
//
// Parameters
//   RESET_PC  word address loaded into the PC on reset
//   CNT_W     width of the jump and branch counters
//
// Ports
//   in_clk           clock, all state changes on its rising edge
//   in_rst           synchronous active-high reset
//   in_pcin          next-PC word address from the next-PC calculator
//   in_halt          halt request (level)
//   in_go            resume request (single-cycle pulse)
//   in_jump          current instruction is an unconditional jump
//   in_branch_taken  current instruction is a taken conditional branch
//   out_pcout        registered current PC
//   out_pc_en        PC load enable for this cycle (combinational)
//   out_halted       high while the FSM is in HALT
//   out_cycles       executed RUN cycles
//   out_jumps        executed unconditional jumps
//   out_branches     taken conditional branches
// ---------------------------------------------------------------------------
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic [31:0]      in_pcin,
  input  logic             in_halt,
  input  logic             in_go,
  input  logic             in_jump,
  input  logic             in_branch_taken,
  output logic [31:0]      out_pcout,
  output logic             out_pc_en,
  output logic             out_halted,
  output logic [31:0]      out_cycles,
  output logic [CNT_W-1:0] out_jumps,
  output logic [CNT_W-1:0] out_branches
);

  // -------------------------------------------------------------------------
  // Fetch-control FSM
  // -------------------------------------------------------------------------
  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHalt = 1'b1
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic        pc_en;
  logic [31:0] pc_q;

  always_comb begin
    state_d = state_q;
    pc_en   = 1'b0;

    unique case (state_q)
      StRun: begin
        // in_go has no meaning while running.
        if (in_halt) begin
          state_d = StHalt;
        end else begin
          pc_en = 1'b1;
        end
      end
      StHalt: begin
        // in_go wins over a still-asserted in_halt so the operator can step
        // past the syscall that caused the halt.
        if (in_go) begin
          pc_en   = 1'b1;
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase

    // Reset overrides everything, including a same-cycle resume.
    if (in_rst) begin
      pc_en   = 1'b0;
      state_d = StRun;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (pc_en) begin
        // Stored verbatim; any wrap-around is the upstream block's business.
        pc_q <= in_pcin;
      end
    end
  end

  assign out_pcout  = pc_q;
  assign out_pc_en  = pc_en;
  assign out_halted = (state_q == StHalt);

  // -------------------------------------------------------------------------
  // Statistics counters
  // -------------------------------------------------------------------------
`ifdef PC_FETCH_STATS_EN
  logic [31:0]      cycles_q;
  logic [CNT_W-1:0] jumps_q;
  logic [CNT_W-1:0] branches_q;

  logic             cycles_inc;
  logic             jumps_inc;
  logic             branches_inc;

  // Cycles count every edge spent in RUN, including the one that enters HALT.
  // The resume edge is spent in HALT and is therefore not counted.
  assign cycles_inc   = (state_q == StRun) && (cycles_q != '1);
  assign jumps_inc    = pc_en && in_jump && (jumps_q != '1);
  assign branches_inc = pc_en && in_branch_taken && (branches_q != '1);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cycles_q   <= '0;
      jumps_q    <= '0;
      branches_q <= '0;
    end else begin
      if (cycles_inc) begin
        cycles_q <= cycles_q + 32'd1;
      end
      if (jumps_inc) begin
        jumps_q <= jumps_q + CNT_W'(1);
      end
      if (branches_inc) begin
        branches_q <= branches_q + CNT_W'(1);
      end
    end
  end

  assign out_cycles   = cycles_q;
  assign out_jumps    = jumps_q;
  assign out_branches = branches_q;
`else
  assign out_cycles   = '0;
  assign out_jumps    = '0;
  assign out_branches = '0;
`endif

  // -------------------------------------------------------------------------
  // Design invariants
  // -------------------------------------------------------------------------
  // The PC may only move when the enable was high on the previous edge.
  property p_pc_hold_when_disabled;
    @(posedge in_clk) disable iff (in_rst)
      !pc_en |=> $stable(pc_q) || $past(in_rst);
  endproperty
  a_pc_hold_when_disabled: assert property (p_pc_hold_when_disabled);

  // Never load the PC while reset is asserted.
  property p_no_en_in_reset;
    @(posedge in_clk) in_rst |-> !pc_en;
  endproperty
  a_no_en_in_reset: assert property (p_no_en_in_reset);

  // Reset always returns the FSM to RUN.
  property p_reset_to_run;
    @(posedge in_clk) in_rst |=> (state_q == StRun);
  endproperty
  a_reset_to_run: assert property (p_reset_to_run);

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch: directed self-checking bench for pc_fetch. Inputs change #1
// after the rising edge and outputs are sampled at the same point, so every
// value is observed well away from the active edge. Counter expectations
// collapse to 0 when PC_FETCH_STATS_EN is undefined.
// ---------------------------------------------------------------------------
module tb_pc_fetch;

  localparam int unsigned CntW = 4;
`ifdef PC_FETCH_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [31:0]     pcin;
  logic            halt;
  logic            go;
  logic            jump;
  logic            branch_taken;
  logic [31:0]     pcout;
  logic            pc_en;
  logic            halted;
  logic [31:0]     cycles;
  logic [CntW-1:0] jumps;
  logic [CntW-1:0] branches;

  int vectors;
  int miscompares;

  pc_fetch #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CntW)
  ) dut (
    .in_clk          (clk),
    .in_rst          (rst),
    .in_pcin         (pcin),
    .in_halt         (halt),
    .in_go           (go),
    .in_jump         (jump),
    .in_branch_taken (branch_taken),
    .out_pcout       (pcout),
    .out_pc_en       (pc_en),
    .out_halted      (halted),
    .out_cycles      (cycles),
    .out_jumps       (jumps),
    .out_branches    (branches)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst          = 1'b0;
    halt         = 1'b0;
    go           = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst  = 1'b1;
    pcin = 32'hDEAD_BEEF;
    tick();
    rst  = 1'b0;
  endtask

  // Reset with conflicting inputs, then check every output.
  task automatic test_reset();
    rst  = 1'b1;
    halt = 1'b1;
    go   = 1'b1;
    jump = 1'b1;
    branch_taken = 1'b1;
    pcin = 32'h1234_5678;
    #1;
    vectors++;
    if (pc_en !== 1'b0) begin
      $display("FAIL reset_pc_en: got %b expected 0", pc_en);
      miscompares++;
    end
    tick();
    tick();
    vectors++;
    if (pcout !== 32'h0) begin
      $display("FAIL reset_pc: got %h expected 00000000", pcout);
      miscompares++;
    end
    vectors++;
    if (halted !== 1'b0) begin
      $display("FAIL reset_halted: got %b expected 0", halted);
      miscompares++;
    end
    vectors++;
    if (cycles !== 32'h0 || jumps !== 4'h0 || branches !== 4'h0) begin
      $display("FAIL reset_counters: got %h/%h/%h expected 0/0/0", cycles, jumps, branches);
      miscompares++;
    end
    idle_inputs();
  endtask

  // Five sequential fetches after reset.
  task automatic test_run();
    logic [31:0] exp_cycles;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pcin = 32'(i + 1);
      #1;
      vectors++;
      if (pc_en !== 1'b1) begin
        $display("FAIL run_pc_en[%0d]: got %b expected 1", i, pc_en);
        miscompares++;
      end
      tick();
      vectors++;
      if (pcout !== 32'(i + 1)) begin
        $display("FAIL run_pc[%0d]: got %h expected %h", i, pcout, 32'(i + 1));
        miscompares++;
      end
    end
    exp_cycles = StatsEn ? 32'd5 : 32'd0;
    vectors++;
    if (cycles !== exp_cycles) begin
      $display("FAIL run_cycles: got %0d expected %0d", cycles, exp_cycles);
      miscompares++;
    end
    vectors++;
    if (halted !== 1'b0) begin
      $display("FAIL run_halted: got %b expected 0", halted);
      miscompares++;
    end
    vectors++;
    if (jumps !== 4'h0 || branches !== 4'h0) begin
      $display("FAIL run_jb: got %h/%h expected 0/0", jumps, branches);
      miscompares++;
    end
  endtask

  // Halt at PC=3 for four cycles, resume with in_halt still high.
  task automatic test_halt_resume();
    logic [31:0] exp_cycles;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pcin = 32'(i + 1);
      tick();
    end
    halt = 1'b1;
    pcin = 32'h0000_0099;
    for (int i = 0; i < 4; i++) begin
      go = (i == 2) ? 1'b0 : 1'b0;
      #1;
      vectors++;
      if (pc_en !== 1'b0) begin
        $display("FAIL halt_pc_en[%0d]: got %b expected 0", i, pc_en);
        miscompares++;
      end
      tick();
      vectors++;
      if (pcout !== 32'd3 || halted !== 1'b1) begin
        $display("FAIL halt_hold[%0d]: got pc=%h halted=%b expected pc=3 halted=1", i, pcout,
                 halted);
        miscompares++;
      end
      // Three RUN cycles plus the one that entered HALT.
      exp_cycles = StatsEn ? 32'd4 : 32'd0;
      vectors++;
      if (cycles !== exp_cycles) begin
        $display("FAIL halt_cycles[%0d]: got %0d expected %0d", i, cycles, exp_cycles);
        miscompares++;
      end
    end
    go   = 1'b1;
    pcin = 32'd4;
    #1;
    vectors++;
    if (pc_en !== 1'b1) begin
      $display("FAIL resume_pc_en: got %b expected 1", pc_en);
      miscompares++;
    end
    tick();
    go   = 1'b0;
    halt = 1'b0;
    vectors++;
    if (pcout !== 32'd4 || halted !== 1'b0) begin
      $display("FAIL resume_pc: got pc=%h halted=%b expected pc=4 halted=0", pcout, halted);
      miscompares++;
    end
    exp_cycles = StatsEn ? 32'd4 : 32'd0;
    vectors++;
    if (cycles !== exp_cycles) begin
      $display("FAIL resume_cycles: got %0d expected %0d", cycles, exp_cycles);
      miscompares++;
    end
    // in_go while running is a no-op.
    go   = 1'b1;
    pcin = 32'd5;
    tick();
    go = 1'b0;
    exp_cycles = StatsEn ? 32'd5 : 32'd0;
    vectors++;
    if (pcout !== 32'd5 || halted !== 1'b0 || cycles !== exp_cycles) begin
      $display("FAIL run_go_ignored: got pc=%h halted=%b cyc=%0d expected 5/0/%0d", pcout,
               halted, cycles, exp_cycles);
      miscompares++;
    end
  endtask

  // Jump and branch together twice, then a jump that coincides with halt.
  task automatic test_jump_branch();
    logic [CntW-1:0] exp_cnt;
    do_reset();
    jump         = 1'b1;
    branch_taken = 1'b1;
    pcin = 32'h0000_0040;
    tick();
    pcin = 32'h0000_0080;
    tick();
    branch_taken = 1'b0;
    halt = 1'b1;
    pcin = 32'h0000_00C0;
    tick();
    exp_cnt = StatsEn ? 4'd2 : 4'd0;
    vectors++;
    if (jumps !== exp_cnt) begin
      $display("FAIL jb_jumps: got %0d expected %0d", jumps, exp_cnt);
      miscompares++;
    end
    vectors++;
    if (branches !== exp_cnt) begin
      $display("FAIL jb_branches: got %0d expected %0d", branches, exp_cnt);
      miscompares++;
    end
    vectors++;
    if (pcout !== 32'h0000_0080 || halted !== 1'b1) begin
      $display("FAIL jb_pc: got pc=%h halted=%b expected 00000080/1", pcout, halted);
      miscompares++;
    end
    idle_inputs();
  endtask

  // Twenty jumps into a 4-bit counter.
  task automatic test_saturate();
    logic [CntW-1:0] exp_cnt;
    do_reset();
    jump = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pcin = 32'(i + 100);
      tick();
      exp_cnt = StatsEn ? ((i + 1 > 15) ? 4'd15 : 4'(i + 1)) : 4'd0;
      vectors++;
      if (jumps !== exp_cnt || branches !== 4'd0) begin
        $display("FAIL sat_jumps[%0d]: got %0d/%0d expected %0d/0", i, jumps, branches, exp_cnt);
        miscompares++;
      end
    end
    idle_inputs();
  endtask

  // Reset while halted at PC=7 with a same-cycle resume; then PC wrap-around.
  task automatic test_reset_in_halt();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      pcin = 32'(i + 1);
      jump = 1'b1;
      tick();
    end
    jump = 1'b0;
    halt = 1'b1;
    tick();
    vectors++;
    if (pcout !== 32'd7 || halted !== 1'b1) begin
      $display("FAIL rih_setup: got pc=%h halted=%b expected 7/1", pcout, halted);
      miscompares++;
    end
    rst  = 1'b1;
    go   = 1'b1;
    pcin = 32'd8;
    #1;
    vectors++;
    if (pc_en !== 1'b0) begin
      $display("FAIL rih_pc_en: got %b expected 0", pc_en);
      miscompares++;
    end
    tick();
    vectors++;
    if (pcout !== 32'd0 || halted !== 1'b0) begin
      $display("FAIL rih_state: got pc=%h halted=%b expected 0/0", pcout, halted);
      miscompares++;
    end
    vectors++;
    if (cycles !== 32'd0 || jumps !== 4'd0 || branches !== 4'd0) begin
      $display("FAIL rih_counters: got %0d/%0d/%0d expected 0/0/0", cycles, jumps, branches);
      miscompares++;
    end
    idle_inputs();
    pcin = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if (pc_en !== 1'b1) begin
      $display("FAIL post_reset_pc_en: got %b expected 1", pc_en);
      miscompares++;
    end
    tick();
    vectors++;
    if (pcout !== 32'hFFFF_FFFF) begin
      $display("FAIL wrap_max: got %h expected ffffffff", pcout);
      miscompares++;
    end
    pcin = 32'h0000_0000;
    tick();
    vectors++;
    if (pcout !== 32'h0000_0000) begin
      $display("FAIL wrap_zero: got %h expected 00000000", pcout);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_inputs();
    pcin = 32'h0;
    test_reset();
    test_run();
    test_halt_resume();
    test_jump_branch();
    test_saturate();
    test_reset_in_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog: the directed sequence is only a few hundred cycles long.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
